// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched from an external table.
// Optional abort input is compiled in when AES_INV_ABORT_EN is defined.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] out_block
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [3:0] NR_L = 4'(NR);

  state_e        fsm_q, fsm_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [127:0]  st_q, st_d;
  logic [127:0]  round_st;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] y;
    y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
    return res;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    for (int i = 0; i < 16; i++)
      res[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      res[127-8*(4*c)   -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      res[127-8*(4*c+1) -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      res[127-8*(4*c+2) -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      res[127-8*(4*c+3) -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return res;
  endfunction

  // The final round (counter 0) skips InvMixColumns.
  always_comb begin
    round_st = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_data;
    if (cnt_q != 4'd0) round_st = inv_mix_columns(round_st);
  end

  // NOTE: every _d starts from its _q so no path leaves it unassigned; that keeps this block free of latches.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    st_d  = st_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in_block ^ rk_data;
          cnt_d = NR_L - 4'd1;
          fsm_d = ROUND;
        end
      end
      ROUND: begin
        st_d = round_st;
        if (cnt_q == 4'd0) fsm_d = DONE;
        else               cnt_d = cnt_q - 4'd1;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
`ifdef AES_INV_ABORT_EN
    if (abort && fsm_q != IDLE) begin
      fsm_d = IDLE;
      cnt_d = 4'd0;
      st_d  = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= 4'd0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
    end
  end

  always_comb begin
    case (fsm_q)
      IDLE:    rk_idx = NR_L;
      ROUND:   rk_idx = cnt_q;
      default: rk_idx = 4'd0;
    endcase
  end

  assign in_ready  = (fsm_q == IDLE) && !rst;
  assign out_valid = (fsm_q == DONE);
  assign out_block = st_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: NR=10/12/14 instances, FIPS-197 vectors plus random blocks vs. a byte-array model.
// Abort scenarios are included when AES_INV_ABORT_EN is defined.
module tb_aes_inv_cipher_iter;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [127:0] in_block  [3];
  logic [3:0]   rk_idx    [3];
  logic [127:0] rk_data   [3];
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] out_block [3];
`ifdef AES_INV_ABORT_EN
  logic [2:0]   abort;
`endif

  logic [127:0] rk_tab [3][16];
  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_inv_cipher_iter #(.NR(10 + 2*g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_block  (in_block[g]),
      .rk_idx    (rk_idx[g]),
      .rk_data   (rk_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
`ifdef AES_INV_ABORT_EN
      .abort     (abort[g]),
`endif
      .out_block (out_block[g])
    );
    assign rk_data[g] = rk_tab[g][rk_idx[g]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa  = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  // S-boxes from the textbook definition: brute-force inverse, then the forward affine map.
  task automatic build_sboxes();
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      s = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) s = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = s[i] ^ s[(i+4)%8] ^ s[(i+5)%8] ^ s[(i+6)%8] ^ s[(i+7)%8] ^ c[i];
      sbox[x]    = b;
      inv_sbox[b] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key 00 01 02 ... expanded for Nk = 4/6/8.
  task automatic build_keys(input int g);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr = 10 + 2*g;
    int nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] ref_decrypt(input int g, input logic [127:0] ct);
    logic [7:0]   st  [16];
    logic [7:0]   ns  [16];
    logic [7:0]   col [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] rk;
    logic [127:0] res;
    int nr = 10 + 2*g;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    rk = rk_tab[g][nr];
    for (int b = 0; b < 16; b++) st[b] = ct[127-8*b -: 8] ^ rk[127-8*b -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      rk = rk_tab[g][r];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          int dst = 4*((c+row)%4) + row;
          ns[dst] = inv_sbox[st[4*c+row]] ^ rk[127-8*dst -: 8];
        end
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) col[k] = ns[4*c+k];
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-row+4)%4], col[k]);
            ns[4*c+row] = acc;
          end
        end
      end
      st = ns;
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = st[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block from IDLE, follow it to DONE, optionally stall, then hand it off.
  task automatic run_block(input int g, input logic [127:0] ct, input logic [127:0] exp, input int hold);
    int nr = 10 + 2*g;
    int edges;
    in_block[g]  = ct;
    in_valid[g]  = 1'b1;
    out_ready[g] = 1'b0;
    check("idle_in_ready", 128'(in_ready[g]), 128'(1));
    check("idle_rk_idx", 128'(rk_idx[g]), 128'(nr));
    step();
    edges = 1;
    in_valid[g] = 1'b0;
    in_block[g] = rand128();
    while (!out_valid[g] && edges < 40) begin
      check("round_rk_idx", 128'(rk_idx[g]), 128'(nr - edges));
      step();
      edges++;
    end
    check("latency_edges", 128'(edges), 128'(nr + 1));
    check("plaintext", out_block[g], exp);
    check("done_in_ready", 128'(in_ready[g]), 128'(0));
    for (int h = 0; h < hold; h++) begin
      in_valid[g] = h[0];
      in_block[g] = rand128();
      step();
      check("hold_valid", 128'(out_valid[g]), 128'(1));
      check("hold_block", out_block[g], exp);
      check("hold_in_ready", 128'(in_ready[g]), 128'(0));
    end
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b1;
    step();
    out_ready[g] = 1'b0;
    check("post_hs_valid", 128'(out_valid[g]), 128'(0));
    check("post_hs_in_ready", 128'(in_ready[g]), 128'(1));
  endtask

  task automatic back_to_back();
    logic [127:0] cts [4];
    logic [127:0] exps [4];
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int last_acc = 0;
    logic acc;
    for (int k = 0; k < 4; k++) begin
      cts[k]  = rand128();
      exps[k] = ref_decrypt(0, cts[k]);
    end
    in_block[0]  = cts[0];
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    while (got < 4 && cyc < 200) begin
      acc = in_ready[0] && in_valid[0];
      if (out_valid[0]) begin
        check("b2b_plaintext", out_block[0], exps[got]);
        check("b2b_in_ready_excl", 128'(in_ready[0]), 128'(0));
        got++;
      end
      if (acc) begin
        if (sent > 0) check("b2b_gap_ge_12", 128'(cyc - last_acc >= 12), 128'(1));
        last_acc = cyc;
        sent++;
      end
      step();
      cyc++;
      if (acc) begin
        if (sent < 4) in_block[0] = cts[sent];
        else          in_valid[0] = 1'b0;
      end
    end
    check("b2b_count", 128'(got), 128'(4));
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
  endtask

  // Start a block on instance 0 and stop once the DUT requests round key r.
  task automatic start_and_wait_round(input int r);
    int n = 0;
    in_block[0] = rand128();
    in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    while (rk_idx[0] != 4'(r) && n < 20) begin
      step();
      n++;
    end
    check("reach_round", 128'(rk_idx[0]), 128'(r));
  endtask

  task automatic expect_quiet(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      seen = seen | out_valid[0];
    end
    check(tag, 128'(seen), 128'(0));
  endtask

  initial begin
    logic [127:0] ct;
    build_sboxes();
    for (int g = 0; g < 3; g++) build_keys(g);
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
`ifdef AES_INV_ABORT_EN
    abort     = '0;
`endif
    for (int g = 0; g < 3; g++) in_block[g] = '0;
    repeat (2) step();
    for (int g = 0; g < 3; g++) begin
      check("rst_in_ready", 128'(in_ready[g]), 128'(0));
      check("rst_out_valid", 128'(out_valid[g]), 128'(0));
      check("rst_out_block", out_block[g], 128'(0));
    end
    rst = 1'b0;
    step();
    for (int g = 0; g < 3; g++) check("post_rst_in_ready", 128'(in_ready[g]), 128'(1));

    run_block(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 0);
    run_block(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 0);
    run_block(2, 128'h8ea2b7ca516745bfeafc49904b496089, PT, 0);

    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 3; k++) begin
        ct = rand128();
        run_block(g, ct, ref_decrypt(g, ct), 0);
      end

    ct = rand128();
    run_block(0, ct, ref_decrypt(0, ct), 20);

    back_to_back();

    start_and_wait_round(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    check("midrst_out_block", out_block[0], 128'(0));
    expect_quiet("midrst_no_valid");
    ct = rand128();
    run_block(0, ct, ref_decrypt(0, ct), 0);

`ifdef AES_INV_ABORT_EN
    start_and_wait_round(3);
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("abort_round_in_ready", 128'(in_ready[0]), 128'(1));
    check("abort_round_out_block", out_block[0], 128'(0));
    expect_quiet("abort_round_no_valid");

    start_and_wait_round(0);
    step();
    check("abort_done_reached", 128'(out_valid[0]), 128'(1));
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    check("abort_done_out_valid", 128'(out_valid[0]), 128'(0));
    check("abort_done_out_block", out_block[0], 128'(0));
    check("abort_done_in_ready", 128'(in_ready[0]), 128'(1));
    ct = rand128();
    run_block(0, ct, ref_decrypt(0, ct), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher (decryption) core. It computes one round per clock using the inverse round transforms InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, following the standard FIPS-197 inverse cipher order. It sits in the decrypt datapath between the block input FIFO and the output stage. Round keys come from an external key-schedule table, indexed by the core.

Parameters:
NR, 10, number of cipher rounds. Legal values are 10, 12 and 14 (AES-128/192/256); any other value must raise an elaboration-time error.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  ciphertext block offered.
in_ready  output  1  core can accept a block.
in_block  input  128  ciphertext. Byte i is at [127-8i -: 8]; column-major state, byte index = 4*col + row.
rk_idx  output  4  round-key index requested this cycle.
rk_data  input  128  round key for rk_idx, valid in the same cycle (combinational table). Same byte order as in_block.
out_valid  output  1  plaintext block available.
out_ready  input  1  downstream accepts the block.
out_block  output  128  plaintext, same byte order.

Behaviour:
- The interface uses one clock. Reset is synchronous and active-high.
- State machine states: IDLE, ROUND, DONE.
- Reset values: FSM = IDLE, round counter = 0, state register = 0, out_valid = 0, out_block = 0. in_ready = 0 while rst is high.
- in_ready = (FSM == IDLE) && !rst, derived combinationally from registered state.
- out_valid = (FSM == DONE). out_block is driven directly from the state register.
- rk_idx is NR in IDLE, the round counter in ROUND, and 0 in DONE (don't-care in DONE).
- IDLE: on in_valid && in_ready, load state <= in_block ^ rk_data (rk[NR]), load counter <= NR-1, go to ROUND. With no handshake, hold.
- ROUND, counter r > 0: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[r])); counter decrements.
- ROUND, r == 0: state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[0]); go to DONE.
- Transform definitions:
  - InvShiftRows rotates row k right by k positions (row 0 unchanged).
  - InvMixColumns uses coefficients {0e,0b,0d,09} over GF(2^8) modulo 0x11b.
  - InvSubBytes may be a 256-entry ROM or computed as GF inverse plus inverse affine; it must be bit-exact with the FIPS-197 inverse S-box.
- DONE: hold out_block stable while out_valid is high and out_ready is low. On out_ready, go to IDLE and clear out_valid.
- Latency: out_valid rises exactly NR+1 clock edges after the accept edge (NR+1 edges after accept, out_valid is high).
- Throughput: one block per NR+2 cycles minimum. in_ready is low in ROUND and DONE, so a new accept is never taken in the same cycle as an output handshake.
- in_block and in_valid are ignored outside IDLE. rk_data is sampled only in IDLE (on accept) and in ROUND.
- Reset asserted mid-operation (ROUND or DONE): the next edge returns to reset values. The partial block is discarded and no out_valid pulse occurs.
- out_ready is ignored unless in DONE.

Optional Feature:
Macro AES_INV_ABORT_EN.
- Defined: adds input port abort (1 bit). abort high at an edge in ROUND or DONE forces IDLE and clears out_valid, the state register and the counter. abort is ignored in IDLE. If abort and rst are high together, rst takes priority (same result). If abort is high in DONE together with out_ready, abort wins: out_valid is already high, so that handshake counts as completed by downstream, but the core takes the abort path.
- Undefined: the abort port is absent and the behaviour is exactly as above.

Test Plan:
- NR=10; key 000102030405060708090a0b0c0d0e0f schedule in bench table; in_block 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block 00112233445566778899aabbccddeeff, with out_valid 11 edges after accept.
- NR=12; key 000102...1617; in_block dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 13 edges. NR=14; key 00..1f; in_block 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 15 edges.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_block is stable, in_ready stays 0 and in_valid pulses are ignored. Then out_ready=1 for 1 cycle -> IDLE and in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with 4 C.1 blocks -> each decrypts correctly. rk_idx sequence per block is 10,9,...,0. Accepts are spaced ≥12 cycles apart with out_ready=1.
- Reset at ROUND r=5 -> next cycle out_valid=0 and in_ready=1. A following block decrypts correctly.
- With AES_INV_ABORT_EN: abort at r=3 -> IDLE with no out_valid. Abort in DONE with out_ready=0 -> out_valid drops the next cycle.
